// File: rtl/ic_skolem_pkg.sv
// Shared types and helpers for the sequential Skolem witness generator
// that solves exists x . (s >>u x) >=s t.
package ic_skolem_pkg;

   // Widest operand the signed-compare helper handles; narrower operands
   // are sign-extended to this width before comparing.
   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } ic_state_t;

   // Width of a counter that must hold every shift amount 0..w.
   function automatic int shw_of(input int w);
      return $clog2(w + 1);
   endfunction

   // Two's-complement a >= b on sign-extended operands.
   function automatic logic sge_w(input logic signed [MAX_W-1:0] a,
                                  input logic signed [MAX_W-1:0] b);
      return a >= b;
   endfunction

endpackage

// File: rtl/ic_lshr_sge_cell.sv
// Combinational cell: hit = (s >>u cnt) >=s t, where cnt >= W shifts
// everything out and yields r = 0.
module ic_lshr_sge_cell
   import ic_skolem_pkg::*;
#(
   parameter int W   = 4,
   parameter int SHW = shw_of(W)
) (
   input  logic [W-1:0]   s,
   input  logic [W-1:0]   t,
   input  logic [SHW-1:0] cnt,
   output logic           hit
);

   logic [W-1:0]             r;
   logic signed [MAX_W-1:0]  r_ext;
   logic signed [MAX_W-1:0]  t_ext;

   // Shift, sign-extend both sides and compare as signed values.
   always_comb begin
      if (cnt >= SHW'(W)) r = '0;
      else                r = s >> cnt;
      r_ext = MAX_W'(signed'(r));
      t_ext = MAX_W'(signed'(t));
      hit   = sge_w(r_ext, t_ext);
   end

endmodule

// File: rtl/ic_bvsge_bvlshr_skolem_seq.sv
// Sequential Skolem witness generator: accepts one (s,t) query, searches
// x = 0..W for the first (s >>u x) >=s t and returns it with a sat flag.
// Optional macro IC_CLOSED_FORM_EN adds a closed-form unsat check at accept
// so unsatisfiable queries skip the search.
module ic_bvsge_bvlshr_skolem_seq
   import ic_skolem_pkg::*;
#(
   parameter int W   = 4,
   parameter int SHW = shw_of(W)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   s_in,
   input  logic [W-1:0]   t_in,
   output logic           out_valid,
   input  logic           out_ready,
   output logic           out_sat,
   output logic [SHW-1:0] out_x
);

   ic_state_t      state_q, state_d;
   logic [W-1:0]   s_q, s_d, t_q, t_d;
   logic [SHW-1:0] cnt_q, cnt_d, x_q, x_d;
   logic           sat_q, sat_d;
   logic           hit;
   logic           ic_ok;

   ic_lshr_sge_cell #(.W(W), .SHW(SHW)) u_search_cell (
      .s   (s_q),
      .t   (t_q),
      .cnt (cnt_q),
      .hit (hit)
   );

`ifdef IC_CLOSED_FORM_EN
   logic hit_one;

   ic_lshr_sge_cell #(.W(W), .SHW(SHW)) u_closed_form_cell (
      .s   (s_in),
      .t   (t_in),
      .cnt (SHW'(1)),
      .hit (hit_one)
   );

   // A witness exists iff x=0 or x=1 already satisfies the bound.
   always_comb begin
      ic_ok = sge_w(MAX_W'(signed'(s_in)), MAX_W'(signed'(t_in))) || hit_one;
   end
`else
   // Without the closed-form check every query goes through the search.
   always_comb begin
      ic_ok = 1'b1;
   end
`endif

   // Next-state and datapath decisions for IDLE / SEARCH / DONE.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      s_d     = s_q;
      t_d     = t_q;
      cnt_d   = cnt_q;
      sat_d   = sat_q;
      x_d     = x_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               s_d   = s_in;
               t_d   = t_in;
               cnt_d = '0;
               sat_d = 1'b0;
               x_d   = '0;
               state_d = ic_ok ? SEARCH : DONE;
            end
         end
         SEARCH: begin
            if (hit) begin
               sat_d   = 1'b1;
               x_d     = cnt_q;
               state_d = DONE;
            end else if (cnt_q == SHW'(W)) begin
               sat_d   = 1'b0;
               x_d     = '0;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + SHW'(1);
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, operand, counter and result registers with async reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         s_q     <= '0;
         t_q     <= '0;
         cnt_q   <= '0;
         sat_q   <= 1'b0;
         x_q     <= '0;
      end else begin
         // NOTE: non-blocking assignments so all registers update together at the edge.
         state_q <= state_d;
         s_q     <= s_d;
         t_q     <= t_d;
         cnt_q   <= cnt_d;
         sat_q   <= sat_d;
         x_q     <= x_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign out_sat   = sat_q;
   assign out_x     = x_q;

endmodule

// File: tb/tb_ic_bvsge_bvlshr_skolem_seq.sv
// Self-checking bench for ic_bvsge_bvlshr_skolem_seq at W=4 and W=8,
// using an exhaustive minimal-x reference model.
module tb_ic_bvsge_bvlshr_skolem_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic       in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b0, out_sat4;
   logic [3:0] s4 = '0, t4 = '0;
   logic [2:0] out_x4;

   logic       in_valid8 = 1'b0, in_ready8, out_valid8, out_ready8 = 1'b0, out_sat8;
   logic [7:0] s8 = '0, t8 = '0;
   logic [3:0] out_x8;

   int n_vec = 0;
   int n_err = 0;

   // Expectations used by the compare process while a result is presented.
   bit mon_en = 1'b0;
   int mon_w  = 4;
   int exp_sat, exp_x;

   always #5 clk = ~clk;

   ic_bvsge_bvlshr_skolem_seq #(.W(4)) dut4 (
      .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
      .s_in(s4), .t_in(t4), .out_valid(out_valid4), .out_ready(out_ready4),
      .out_sat(out_sat4), .out_x(out_x4)
   );

   ic_bvsge_bvlshr_skolem_seq #(.W(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .s_in(s8), .t_in(t8), .out_valid(out_valid8), .out_ready(out_ready8),
      .out_sat(out_sat8), .out_x(out_x8)
   );

   task automatic check(input string name, input int actual, input int expected);
      n_vec++;
      if (actual !== expected) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic int to_signed(input int v, input int w);
      return (v >= (1 << (w - 1))) ? v - (1 << w) : v;
   endfunction

   // Reference: try every shift amount in order, first hit is the answer.
   task automatic model(input int w, input int s, input int t,
                        output int sat, output int x, output int lat);
      sat = 0; x = 0;
`ifdef IC_CLOSED_FORM_EN
      lat = 1;
`else
      lat = w + 2;
`endif
      for (int xi = 0; xi <= w; xi++) begin
         int r;
         r = (xi >= w) ? 0 : (s >> xi);
         if (to_signed(r, w) >= to_signed(t, w)) begin
            sat = 1; x = xi; lat = xi + 2;
            return;
         end
      end
   endtask

   task automatic drive(input int w, input logic iv, input logic ordy, input int s, input int t);
      if (w == 4) begin
         in_valid4 = iv; out_ready4 = ordy; s4 = 4'(s); t4 = 4'(t);
      end else begin
         in_valid8 = iv; out_ready8 = ordy; s8 = 8'(s); t8 = 8'(t);
      end
   endtask

   task automatic sample(input int w, output logic ov, output logic ir,
                         output logic sat, output int x);
      if (w == 4) begin
         ov = out_valid4; ir = in_ready4; sat = out_sat4; x = int'(out_x4);
      end else begin
         ov = out_valid8; ir = in_ready8; sat = out_sat8; x = int'(out_x8);
      end
   endtask

   // Compare process: whenever a result is presented, it must match the model.
   always @(negedge clk) begin
      logic ov, ir, sat;
      int   x;
      if (mon_en && !rst) begin
         sample(mon_w, ov, ir, sat, x);
         if (ov) begin
            check("out_sat", int'(sat), exp_sat);
            check("out_x", x, exp_x);
            check("in_ready_in_done", int'(ir), 0);
         end
      end
   end

   // One full query: issue, wait for the result, hold it, hand it off.
   task automatic run_query(input int w, input int s, input int t, input int hold);
      int   sat, x, lat, cyc;
      logic ov, ir, osat;
      int   ox;
      model(w, s, t, sat, x, lat);
      @(negedge clk);
      sample(w, ov, ir, osat, ox);
      check("in_ready_idle", int'(ir), 1);
      drive(w, 1'b1, 1'b0, s, t);
      @(posedge clk);
      #1;
      drive(w, 1'b0, 1'b0, 0, 0);
      mon_w = w; exp_sat = sat; exp_x = x; mon_en = 1'b1;
      cyc = 0;
      do begin
         @(negedge clk);
         cyc++;
         sample(w, ov, ir, osat, ox);
      end while (!ov && cyc < lat + 4);
      check("latency", ov ? cyc : -1, lat);
      // Hold the result; a stray query on the inputs must be ignored.
      for (int i = 0; i < hold; i++) begin
         drive(w, 1'b1, 1'b0, $urandom, $urandom);
         @(negedge clk);
         sample(w, ov, ir, osat, ox);
         check("out_valid_hold", int'(ov), 1);
      end
      drive(w, 1'b1, 1'b1, $urandom, $urandom);
      @(posedge clk);
      #1;
      drive(w, 1'b0, 1'b0, 0, 0);
      mon_en = 1'b0;
      @(negedge clk);
      sample(w, ov, ir, osat, ox);
      check("back_to_idle_ready", int'(ir), 1);
      check("back_to_idle_valid", int'(ov), 0);
   endtask

   initial begin
      int sat, x, lat;
      logic ov, ir, osat;
      int   ox;

      // Pin the model against hand-computed answers.
      model(4, 4'b1000, 4'b0011, sat, x, lat);
      check("model_c1_sat", sat, 1); check("model_c1_x", x, 1); check("model_c1_lat", lat, 3);
      model(4, 4'b0101, 4'b0110, sat, x, lat);
      check("model_c2_sat", sat, 0); check("model_c2_x", x, 0);
`ifdef IC_CLOSED_FORM_EN
      check("model_c2_lat", lat, 1);
`else
      check("model_c2_lat", lat, 6);
`endif
      model(4, 4'b0000, 4'b1111, sat, x, lat);
      check("model_c3_sat", sat, 1); check("model_c3_x", x, 0); check("model_c3_lat", lat, 2);

      // Reset values while reset is held.
      #12;
      check("rst_in_ready", int'(in_ready4), 1);
      check("rst_out_valid", int'(out_valid4), 0);
      check("rst_out_sat", int'(out_sat4), 0);
      check("rst_out_x", int'(out_x4), 0);
      @(negedge clk);
      rst = 1'b0;

      // Directed cases 1-3, then case 4 with a 5-cycle stall.
      run_query(4, 4'b1000, 4'b0011, 0);
      run_query(4, 4'b0101, 4'b0110, 0);
      run_query(4, 4'b0000, 4'b1111, 0);
      run_query(4, 4'b1000, 4'b0011, 5);

      // Case 5: reset in the middle of case 2 aborts it.
      @(negedge clk);
      drive(4, 1'b1, 1'b0, 4'b0101, 4'b0110);
      @(posedge clk);
      #1;
      drive(4, 1'b0, 1'b0, 0, 0);
      repeat (2) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      sample(4, ov, ir, osat, ox);
      check("midrst_in_ready", int'(ir), 1);
      check("midrst_out_valid", int'(ov), 0);
      check("midrst_out_sat", int'(osat), 0);
      check("midrst_out_x", ox, 0);
      @(negedge clk);
      rst = 1'b0;
      run_query(4, 4'b1000, 4'b0011, 0);

      // Random queries at both widths.
      for (int i = 0; i < 60; i++)
         run_query(4, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 2)));
      for (int i = 0; i < 60; i++)
         run_query(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                   int'($urandom_range(0, 2)));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
